raid5_top: RTL and testbench

- RAID-5 controller core between an AHB-side request port, a word cache and three SD cards.
- Stripes 31-bit logical word addresses across three SD cards with rotating XOR parity.
- Reads are served from the cache on a hit. On a miss the word is fetched from SD, reconstructed if one card is in error, and filled into the cache.
- Writes are read-modify-write to SD with parity update, followed by a write-through update of the cache on a hit.

---
 rtl/raid5_top.sv | 232 +++++++++++++++++++++++
 tb/tb_raid5_top.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raid5_top.sv
// RAID-5 controller core: stripes word addresses over three SD cards
// with rotating parity and a word cache in front of the read path.
module raid5_top (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        h_ready,
   input  logic [31:0] ahb_address,
   input  logic [31:0] ahb_cache_in_data,
   output logic        ahb_done,
   output logic [31:0] cache_ahb_out_data,
   output logic        sd_mode,
   output logic        sd_start,
   output logic [31:0] sd_block_no,
   output logic        sd_read_enable,
   output logic        sd_write_enable,
   input  logic [1:0]  sd1_error,
   input  logic [1:0]  sd2_error,
   input  logic [1:0]  sd3_error,
   output logic [31:0] sd1in,
   output logic [31:0] sd2in,
   output logic [31:0] sd3in,
   input  logic [31:0] sd1out,
   input  logic [31:0] sd2out,
   input  logic [31:0] sd3out,
   input  logic        sd_ready,
   output logic [2:0]  cache_mode,
   output logic [31:0] cache_in,
   output logic [31:0] cache_block_no,
   output logic [7:0]  cache_offset,
   input  logic        exists,
   input  logic        full,
   input  logic [31:0] cache_out
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOOK, S_LOOKW, S_CRD, S_CRDW,
      S_RDS, S_RDW, S_RDC, S_EVICT, S_FILL,
      S_WRS, S_WRW, S_WRE, S_DONE
   } state_t;

   localparam logic [2:0] CM_IDLE  = 3'd0;
   localparam logic [2:0] CM_LOOK  = 3'd1;
   localparam logic [2:0] CM_READ  = 3'd2;
   localparam logic [2:0] CM_WRITE = 3'd3;
   localparam logic [2:0] CM_EVICT = 3'd4;

   state_t      state_q, state_d;
   logic [30:0] addr_q, addr_d;
   logic        rd_q, rd_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] oth_q, oth_d;
   logic [31:0] out_q, out_d;

   logic [29:0] stripe;
   logic [1:0]  par, tgt, oth_i;
   logic [31:0] dv [4];
   logic [3:0]  bad;
   logic        multi;
   logic [31:0] tgt_word, oth_word, new_par;
   logic        wr_drive;

   // Stripe layout: parity rotates, remaining cards hold data0/data1
   always_comb begin
      stripe   = addr_q[30:1];
      par      = 2'(stripe % 30'd3);
      tgt      = '0;
      oth_i    = '0;
      if (par == 2'd0) begin
         tgt   = addr_q[0] ? 2'd2 : 2'd1;
         oth_i = addr_q[0] ? 2'd1 : 2'd2;
      end else if (par == 2'd1) begin
         tgt   = addr_q[0] ? 2'd2 : 2'd0;
         oth_i = addr_q[0] ? 2'd0 : 2'd2;
      end else begin
         tgt   = addr_q[0] ? 2'd1 : 2'd0;
         oth_i = addr_q[0] ? 2'd0 : 2'd1;
      end
   end

   // Card words with single-failure reconstruction by XOR of survivors
   always_comb begin
      dv[0]    = sd1out;
      dv[1]    = sd2out;
      dv[2]    = sd3out;
      dv[3]    = '0;
      bad      = {1'b0, |sd3_error, |sd2_error, |sd1_error};
      multi    = (bad[0] & bad[1]) | (bad[0] & bad[2]) | (bad[1] & bad[2]);
      tgt_word = '0;
      oth_word = '0;
      if (!multi) begin
         tgt_word = bad[tgt]   ? (dv[oth_i] ^ dv[par]) : dv[tgt];
         oth_word = bad[oth_i] ? (dv[tgt] ^ dv[par])   : dv[oth_i];
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wdata_q <= '0;
         oth_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wdata_q <= wdata_d;
         oth_q   <= oth_d;
         out_q   <= out_d;
      end
   end

   // Next-state and Moore outputs
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      rd_d            = rd_q;
      wdata_d         = wdata_q;
      oth_d           = oth_q;
      out_d           = out_q;
      ahb_done        = 1'b0;
      sd_mode         = 1'b0;
      sd_start        = 1'b0;
      sd_read_enable  = 1'b0;
      sd_write_enable = 1'b0;
      cache_mode      = CM_IDLE;
      cache_in        = '0;
      wr_drive        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!h_ready) begin
               addr_d  = ahb_address[30:0];
               rd_d    = ahb_address[31];
               wdata_d = ahb_cache_in_data;
               state_d = ahb_address[31] ? S_LOOK : S_RDS;
            end
         end
         S_LOOK: begin
            cache_mode = CM_LOOK;
            state_d    = S_LOOKW;
         end
         S_LOOKW: begin
            if (rd_q) state_d = exists ? S_CRD : S_RDS;
            else      state_d = exists ? S_FILL : S_DONE;
         end
         S_CRD: begin
            cache_mode = CM_READ;
            state_d    = S_CRDW;
         end
         S_CRDW: begin
            out_d   = cache_out;
            state_d = S_DONE;
         end
         S_RDS: begin
            sd_mode  = 1'b1;
            sd_start = 1'b1;
            state_d  = S_RDW;
         end
         S_RDW: begin
            sd_mode = 1'b1;
            if (sd_ready) state_d = S_RDC;
         end
         S_RDC: begin
            sd_mode        = 1'b1;
            sd_read_enable = 1'b1;
            oth_d          = oth_word;
            if (rd_q) begin
               out_d   = tgt_word;
               state_d = full ? S_EVICT : S_FILL;
            end else begin
               state_d = S_WRS;
            end
         end
         S_EVICT: begin
            cache_mode = CM_EVICT;
            state_d    = S_FILL;
         end
         S_FILL: begin
            cache_mode = CM_WRITE;
            cache_in   = rd_q ? out_q : wdata_q;
            state_d    = S_DONE;
         end
         S_WRS: begin
            sd_start = 1'b1;
            wr_drive = 1'b1;
            state_d  = S_WRW;
         end
         S_WRW: begin
            wr_drive = 1'b1;
            if (sd_ready) state_d = S_WRE;
         end
         S_WRE: begin
            wr_drive        = 1'b1;
            sd_write_enable = 1'b1;
            state_d         = S_LOOK;
         end
         S_DONE: begin
            ahb_done = 1'b1;
            if (h_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Card write data: target gets new data, parity card the new parity
   always_comb begin
      new_par = wdata_q ^ oth_q;
      sd1in   = '0;
      sd2in   = '0;
      sd3in   = '0;
      if (wr_drive) begin
         sd1in = (tgt == 2'd0) ? wdata_q : (par == 2'd0) ? new_par : oth_q;
         sd2in = (tgt == 2'd1) ? wdata_q : (par == 2'd1) ? new_par : oth_q;
         sd3in = (tgt == 2'd2) ? wdata_q : (par == 2'd2) ? new_par : oth_q;
      end
   end

   // Address fields toward the cache and the cards
   always_comb begin
      cache_ahb_out_data = out_q;
      sd_block_no        = {2'b0, addr_q[30:1]};
      cache_block_no     = '0;
      cache_offset       = '0;
      if (cache_mode != CM_IDLE) begin
         cache_block_no = {8'b0, addr_q[30:7]};
         cache_offset   = {1'b0, addr_q[6:0]};
      end
   end

endmodule

// File: tb/tb_raid5_top.sv
// Bench for raid5_top: card/cache stubs, a striped-disk reference
// model and randomized read/write traffic.
module tb_raid5_top;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        h_ready = 1'b1;
   logic [31:0] ahb_address = '0;
   logic [31:0] ahb_cache_in_data = '0;
   logic        ahb_done;
   logic [31:0] cache_ahb_out_data;
   logic        sd_mode, sd_start, sd_read_enable, sd_write_enable;
   logic [31:0] sd_block_no;
   logic [1:0]  sd1_error = '0, sd2_error = '0, sd3_error = '0;
   logic [31:0] sd1in, sd2in, sd3in;
   logic [31:0] sd1out, sd2out, sd3out;
   logic        sd_ready = 1'b0;
   logic [2:0]  cache_mode;
   logic [31:0] cache_in, cache_block_no;
   logic [7:0]  cache_offset;
   logic        exists = 1'b0, full = 1'b0;
   logic [31:0] cache_out = '0;

   logic [31:0] disk [3][16];
   int tests = 0;
   int fails = 0;
   logic [31:0] last_read = '0;

   int n_start = 0, n_evict = 0, n_cwr = 0, n_crd = 0, n_wr = 0, n_rde = 0;
   int cyc = 0, evict_cyc = 0, cwr_cyc = 0;
   logic [31:0] c_in = '0, blk_start = '0;
   logic [31:0] w_in [3];
   logic pend = 1'b0;
   int dly = 0;

   raid5_top dut (
      .clk(clk), .n_rst(n_rst), .h_ready(h_ready),
      .ahb_address(ahb_address), .ahb_cache_in_data(ahb_cache_in_data),
      .ahb_done(ahb_done), .cache_ahb_out_data(cache_ahb_out_data),
      .sd_mode(sd_mode), .sd_start(sd_start), .sd_block_no(sd_block_no),
      .sd_read_enable(sd_read_enable), .sd_write_enable(sd_write_enable),
      .sd1_error(sd1_error), .sd2_error(sd2_error), .sd3_error(sd3_error),
      .sd1in(sd1in), .sd2in(sd2in), .sd3in(sd3in),
      .sd1out(sd1out), .sd2out(sd2out), .sd3out(sd3out),
      .sd_ready(sd_ready), .cache_mode(cache_mode), .cache_in(cache_in),
      .cache_block_no(cache_block_no), .cache_offset(cache_offset),
      .exists(exists), .full(full), .cache_out(cache_out)
   );

   always #5 clk = ~clk;

   assign sd1out = disk[0][sd_block_no[3:0]];
   assign sd2out = disk[1][sd_block_no[3:0]];
   assign sd3out = disk[2][sd_block_no[3:0]];

   // Card responder and event recorder, sampled mid-cycle
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!n_rst) begin
         sd_ready = 1'b0;
         pend = 1'b0;
      end else begin
         if (sd_start) begin
            n_start = n_start + 1;
            blk_start = sd_block_no;
            pend = 1'b1;
            dly = $urandom_range(0, 3);
            sd_ready = 1'b0;
         end else if (pend && !sd_ready) begin
            if (dly == 0) sd_ready = 1'b1;
            else dly = dly - 1;
         end
         if (sd_read_enable) n_rde = n_rde + 1;
         if (sd_write_enable) begin
            n_wr = n_wr + 1;
            w_in[0] = sd1in;
            w_in[1] = sd2in;
            w_in[2] = sd3in;
         end
         if (sd_read_enable || sd_write_enable) begin
            sd_ready = 1'b0;
            pend = 1'b0;
         end
         if (cache_mode == 3'd4) begin
            n_evict = n_evict + 1;
            evict_cyc = cyc;
         end
         if (cache_mode == 3'd3) begin
            n_cwr = n_cwr + 1;
            cwr_cyc = cyc;
            c_in = cache_in;
         end
         if (cache_mode == 3'd2) n_crd = n_crd + 1;
      end
   end

   // A failed card reads as the XOR of the other two; 2+ failures give 0
   function automatic logic [31:0] card_val(input int i, input int s,
                                            input logic [2:0] bad);
      int n;
      n = int'(bad[0]) + int'(bad[1]) + int'(bad[2]);
      if (n >= 2) return '0;
      if (!bad[i]) return disk[i][s];
      return disk[(i + 1) % 3][s] ^ disk[(i + 2) % 3][s];
   endfunction

   task automatic do_req(input logic rd, input logic [30:0] l,
                         input logic [31:0] wd, input logic ex,
                         input logic fl, input logic [31:0] co,
                         input logic [2:0] bad, output logic to);
      @(negedge clk);
      ahb_address = {rd, l};
      ahb_cache_in_data = wd;
      exists = ex;
      full = fl;
      cache_out = co;
      sd1_error = bad[0] ? 2'($urandom_range(1, 3)) : 2'd0;
      sd2_error = bad[1] ? 2'($urandom_range(1, 3)) : 2'd0;
      sd3_error = bad[2] ? 2'($urandom_range(1, 3)) : 2'd0;
      h_ready = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ahb_done) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic release_req();
      h_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      ahb_address = $urandom;
      ahb_cache_in_data = $urandom;
      h_ready = 1'b0;
      exists = 1'b1;
      full = 1'b1;
      cache_out = $urandom;
      sd1_error = 2'd1;
      repeat (3) @(negedge clk);
      tests++;
      if (ahb_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_done got %b want 0", ahb_done);
      end
      tests++;
      if (cache_mode !== 3'd0) begin
         fails++;
         $display("FAIL reset_cache_mode got %0d want 0", cache_mode);
      end
      tests++;
      if ({cache_ahb_out_data, sd_mode, sd_start, sd_block_no,
           sd_read_enable, sd_write_enable, sd1in, sd2in, sd3in,
           cache_in, cache_block_no, cache_offset} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got nonzero want all 0 (blk %h in %h)",
                  sd_block_no, cache_in);
      end
      h_ready = 1'b1;
      sd1_error = 2'd0;
      exists = 1'b0;
      full = 1'b0;
      n_rst = 1'b1;
      last_read = '0;
      @(negedge clk);
   endtask

   task automatic test_read_miss();
      logic to;
      int s0, e0;
      disk[0][0] = 32'h6666_6666;
      disk[1][0] = 32'hFFFF_FFFF;
      disk[2][0] = 32'h9999_9999;
      s0 = n_start;
      e0 = n_evict;
      do_req(1'b1, 31'd0, '0, 1'b0, 1'b0, '0, 3'b000, to);
      tests++;
      if (to !== 1'b0) begin
         fails++;
         $display("FAIL miss_timeout got no done want done");
      end
      tests++;
      if (blk_start !== 32'd0 || n_start - s0 !== 1) begin
         fails++;
         $display("FAIL miss_sd got blk %h starts %0d want 0 and 1",
                  blk_start, n_start - s0);
      end
      tests++;
      if (c_in !== 32'hFFFF_FFFF || n_evict != e0) begin
         fails++;
         $display("FAIL miss_fill got %h evict %0d want FFFFFFFF 0",
                  c_in, n_evict - e0);
      end
      tests++;
      if (cache_ahb_out_data !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL miss_data got %h want FFFFFFFF", cache_ahb_out_data);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (ahb_done !== 1'b1) begin
         fails++;
         $display("FAIL hold_done got %b want 1", ahb_done);
      end
      release_req();
      repeat (4) @(negedge clk);
      tests++;
      if (ahb_done !== 1'b0 || n_start - s0 !== 1) begin
         fails++;
         $display("FAIL release got done %b starts %0d want 0 1",
                  ahb_done, n_start - s0);
      end
      last_read = 32'hFFFF_FFFF;
   endtask

   task automatic test_degraded();
      logic to;
      int e0, w0;
      e0 = n_evict;
      w0 = n_cwr;
      do_req(1'b1, 31'd0, '0, 1'b0, 1'b1, '0, 3'b010, to);
      tests++;
      if (to !== 1'b0 || cache_ahb_out_data !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL degraded_data got %h to %b want FFFFFFFF",
                  cache_ahb_out_data, to);
      end
      tests++;
      if (n_evict - e0 !== 1 || n_cwr - w0 !== 1 ||
          cwr_cyc !== evict_cyc + 1) begin
         fails++;
         $display("FAIL degraded_evict got ev %0d wr %0d want 1 1 adjacent",
                  n_evict - e0, n_cwr - w0);
      end
      release_req();
      last_read = 32'hFFFF_FFFF;
   endtask

   task automatic test_read_hit();
      logic to;
      int s0, w0, r0;
      s0 = n_start;
      w0 = n_cwr;
      r0 = n_crd;
      do_req(1'b1, 31'd200, '0, 1'b1, 1'b1, 32'h1234_5678, 3'b000, to);
      tests++;
      if (to !== 1'b0 || cache_ahb_out_data !== 32'h1234_5678) begin
         fails++;
         $display("FAIL hit_data got %h want 12345678", cache_ahb_out_data);
      end
      tests++;
      if (n_start != s0 || n_cwr != w0 || n_crd - r0 !== 1) begin
         fails++;
         $display("FAIL hit_path got st %0d wr %0d rd %0d want 0 0 1",
                  n_start - s0, n_cwr - w0, n_crd - r0);
      end
      release_req();
      last_read = 32'h1234_5678;
   endtask

   task automatic test_write();
      logic to;
      int w0, e0;
      disk[0][0] = 32'h6666_6666;
      disk[1][0] = 32'hFFFF_FFFF;
      disk[2][0] = 32'h9999_9999;
      w0 = n_cwr;
      e0 = n_evict;
      do_req(1'b0, 31'd1, 32'h7777_7777, 1'b1, 1'b1, '0, 3'b000, to);
      tests++;
      if (to !== 1'b0) begin
         fails++;
         $display("FAIL write_timeout got no done want done");
      end
      tests++;
      if (w_in[0] !== 32'h8888_8888 || w_in[1] !== 32'hFFFF_FFFF ||
          w_in[2] !== 32'h7777_7777) begin
         fails++;
         $display("FAIL write_cards got %h %h %h want 88888888 FFFFFFFF 77777777",
                  w_in[0], w_in[1], w_in[2]);
      end
      tests++;
      if (n_cwr - w0 !== 1 || c_in !== 32'h7777_7777 || n_evict != e0) begin
         fails++;
         $display("FAIL write_cache got %h wr %0d ev %0d want 77777777 1 0",
                  c_in, n_cwr - w0, n_evict - e0);
      end
      tests++;
      if (cache_ahb_out_data !== last_read) begin
         fails++;
         $display("FAIL write_out got %h want %h", cache_ahb_out_data, last_read);
      end
      release_req();
      disk[0][0] = 32'h8888_8888;
      disk[2][0] = 32'h7777_7777;
   endtask

   task automatic test_random();
      logic to, rd, ex, fl;
      logic [30:0] l;
      logic [31:0] wd, co, word, ov, exp_out;
      logic [31:0] ew [3];
      logic [2:0] bad;
      int s, p, d0, d1, t, o, r, s0, w0, e0, k;
      for (int it = 0; it < 60; it++) begin
         l = 31'($urandom_range(0, 31));
         rd = 1'($urandom_range(0, 1));
         ex = 1'($urandom_range(0, 1));
         fl = 1'($urandom_range(0, 1));
         co = $urandom;
         wd = $urandom;
         r = $urandom_range(0, 9);
         bad = 3'b000;
         if (r >= 7) begin
            k = $urandom_range(0, 2);
            bad[k] = 1'b1;
         end
         if (r == 9) bad[(k + 1) % 3] = 1'b1;
         s = int'(l >> 1);
         p = s % 3;
         d0 = (p == 0) ? 1 : 0;
         d1 = (p == 2) ? 1 : 2;
         t = l[0] ? d1 : d0;
         o = l[0] ? d0 : d1;
         word = card_val(t, s, bad);
         ov = card_val(o, s, bad);
         s0 = n_start;
         w0 = n_cwr;
         e0 = n_evict;
         do_req(rd, l, wd, ex, fl, co, bad, to);
         tests++;
         if (to !== 1'b0) begin
            fails++;
            $display("FAIL rand_timeout it %0d got no done want done", it);
         end
         if (rd) begin
            exp_out = ex ? co : word;
            tests++;
            if (cache_ahb_out_data !== exp_out) begin
               fails++;
               $display("FAIL rand_read it %0d L %0d got %h want %h",
                        it, l, cache_ahb_out_data, exp_out);
            end
            if (!ex) begin
               tests++;
               if (c_in !== word || n_evict - e0 !== int'(fl) ||
                   n_start - s0 !== 1) begin
                  fails++;
                  $display("FAIL rand_fill it %0d got %h ev %0d want %h ev %0d",
                           it, c_in, n_evict - e0, word, fl);
               end
            end
            last_read = exp_out;
         end else begin
            ew[t] = wd;
            ew[p] = wd ^ ov;
            ew[o] = ov;
            tests++;
            if (w_in[0] !== ew[0] || w_in[1] !== ew[1] || w_in[2] !== ew[2]) begin
               fails++;
               $display("FAIL rand_write it %0d L %0d got %h %h %h want %h %h %h",
                        it, l, w_in[0], w_in[1], w_in[2], ew[0], ew[1], ew[2]);
            end
            tests++;
            if (n_cwr - w0 !== int'(ex) || (ex && c_in !== wd) ||
                n_evict != e0 || cache_ahb_out_data !== last_read) begin
               fails++;
               $display("FAIL rand_wcache it %0d got wr %0d %h out %h want %0d %h %h",
                        it, n_cwr - w0, c_in, cache_ahb_out_data, ex, wd, last_read);
            end
            for (int i = 0; i < 3; i++) disk[i][s] = ew[i];
         end
         release_req();
         tests++;
         if (ahb_done !== 1'b0) begin
            fails++;
            $display("FAIL rand_release it %0d got %b want 0", it, ahb_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      int s0;
      seen = 1'b0;
      sd1_error = '0;
      sd2_error = '0;
      sd3_error = '0;
      @(negedge clk);
      ahb_address = {1'b0, 31'd5};
      ahb_cache_in_data = 32'hA5A5_A5A5;
      h_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (sd_start) begin
            seen = 1'b1;
            break;
         end
      end
      n_rst = 1'b0;
      h_ready = 1'b1;
      #1;
      tests++;
      if (!seen || sd_start !== 1'b0 || sd_mode !== 1'b0 ||
          ahb_done !== 1'b0 || cache_mode !== 3'd0) begin
         fails++;
         $display("FAIL reset_mid got seen %b start %b mode %b want 1 0 0",
                  seen, sd_start, sd_mode);
      end
      @(negedge clk);
      n_rst = 1'b1;
      s0 = n_start;
      repeat (10) @(negedge clk);
      tests++;
      if (n_start != s0 || ahb_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle got starts %0d done %b want 0 0",
                  n_start - s0, ahb_done);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 16; j++) disk[i][j] = $urandom;
      w_in[0] = '0;
      w_in[1] = '0;
      w_in[2] = '0;
      test_reset();
      test_read_miss();
      test_degraded();
      test_read_hit();
      test_write();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
